// File: rtl/kypd_pkg.sv
// Shared types and constants for the 4x4 keypad column-scan controller.
package kypd_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, EVAL} scan_state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} cand_kind_t;

  localparam int NUM_COLS = 4;

  // Indexed [row][col]; rows and columns counted from the keypad's own 0 pin.
  localparam logic [3:0] KYPD_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

endpackage

// File: rtl/kypd_row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows.
module kypd_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] row_sync
);

  logic [3:0] meta;

  // Idle rows read high, so reset to "nothing pressed".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta     <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      meta     <= row_n;
      row_sync <= meta;
    end
  end

endmodule

// File: rtl/kypd_scan_ctrl.sv
// Column-scan keypad controller: scans, classifies and debounces whole-scan results.
import kypd_pkg::*;

module kypd_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_err
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = CW'(DEBOUNCE_SCANS);
  localparam logic [1:0]    LAST_COL    = 2'(NUM_COLS - 1);

  scan_state_t   state, state_nx;
  logic [1:0]    col_idx;
  logic [SW-1:0] settle_cnt;
  logic [15:0]   scan_map;
  logic [3:0]    row_sync;
  logic [CW-1:0] cnt, cnt_nx;
  cand_kind_t    last_kind, cand_kind;
  logic [3:0]    last_code, cand_code;
  logic [1:0]    ones;
  logic [3:0]    idx;
  logic          same, accept;

  kypd_row_sync u_row_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .row_sync (row_sync)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    col_n    = 4'hF;
    case (state)
      IDLE:   if (en) state_nx = DRIVE;
      DRIVE: begin
        col_n = ~(4'b0001 << col_idx);
        if (settle_cnt == SETTLE_LAST) state_nx = SAMPLE;
      end
      SAMPLE: begin
        col_n    = ~(4'b0001 << col_idx);
        state_nx = (col_idx == LAST_COL) ? EVAL : DRIVE;
      end
      EVAL:    state_nx = DRIVE;
      default: state_nx = IDLE;
    endcase
    if (!en) state_nx = IDLE;
  end

  // Bit 4*col+row of scan_map is set when that key was seen closed; ones saturates at 2.
  always_comb begin
    ones      = 2'd0;
    idx       = 4'd0;
    cand_kind = NONE;
    cand_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (scan_map[i]) begin
        idx = 4'(i);
        if (ones != 2'd2) ones = ones + 2'd1;
      end
    end
    if (ones == 2'd1) begin
      cand_kind = SINGLE;
      cand_code = KYPD_MAP[idx[1:0]][idx[3:2]];
    end else if (ones == 2'd2) begin
      cand_kind = MULTI;
    end
    same   = (cand_kind == last_kind) && (cand_code == last_code);
    cnt_nx = !same ? CW'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
    accept = (cnt_nx == CNT_MAX) && !(same && (cnt == CNT_MAX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_idx    <= 2'd0;
      settle_cnt <= '0;
      scan_map   <= 16'h0;
      cnt        <= '0;
      last_kind  <= NONE;
      last_code  <= 4'h0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (!en) begin
        col_idx    <= 2'd0;
        settle_cnt <= '0;
        cnt        <= '0;
        last_kind  <= NONE;
        last_code  <= 4'h0;
        key_held   <= 1'b0;
        key_err    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            col_idx    <= 2'd0;
            settle_cnt <= '0;
          end
          DRIVE: settle_cnt <= (settle_cnt == SETTLE_LAST) ? '0 : settle_cnt + 1'b1;
          SAMPLE: begin
            scan_map[4*col_idx +: 4] <= ~row_sync;
            if (col_idx != LAST_COL) col_idx <= col_idx + 2'd1;
          end
          EVAL: begin
            col_idx   <= 2'd0;
            cnt       <= cnt_nx;
            last_kind <= cand_kind;
            last_code <= cand_code;
            if (accept) begin
              case (cand_kind)
                SINGLE: begin
                  // A key that is already held never re-strobes.
                  if (!key_held || (cand_code != key_code)) begin
                    key_code  <= cand_code;
                    key_valid <= 1'b1;
                    key_held  <= 1'b1;
                    key_err   <= 1'b0;
                  end
                end
                NONE: begin
                  key_held <= 1'b0;
                  key_err  <= 1'b0;
                end
                MULTI: begin
                  key_held <= 1'b0;
                  key_err  <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Self-checking bench for kypd_scan_ctrl: keypad switch model plus a per-scan reference model.
module tb_kypd_scan_ctrl;
  import kypd_pkg::*;

  localparam int SETTLE = 8;
  localparam int DEB    = 3;
  localparam int PERIOD = 4 * (SETTLE + 1) + 1;
  localparam int COLW   = SETTLE + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n, key_code;
  logic       key_valid, key_held, key_err;
  logic [15:0] pressed = 16'h0;

  int checks = 0;
  int errors = 0;

  // Reference model state, updated once per completed scan.
  logic [3:0] m_code = 4'h0;
  logic       m_held = 1'b0;
  logic       m_err  = 1'b0;
  logic       m_pend = 1'b0;
  int         m_last_kind = 0;
  logic [3:0] m_last_code = 4'h0;
  int         m_run = 0;

  kypd_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  // Closed switch at (row r, col c) pulls row r low while column c is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_n[c])
        for (int r = 0; r < 4; r++)
          if (pressed[4*c+r]) row_n[r] = 1'b0;
  end

  function automatic logic [3:0] ref_code(input int r, input int c);
    logic [63:0] t;
    t = 64'h123A_456B_789C_0FED;
    return t[63-4*(4*r+c) -: 4];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_code = 4'h0; m_held = 1'b0; m_err = 1'b0; m_pend = 1'b0;
    m_last_kind = 0; m_last_code = 4'h0; m_run = 0;
  endtask

  task automatic model_eval(input logic [15:0] mask);
    int n, kind;
    logic [3:0] code;
    n = $countones(mask);
    kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
    code = 4'h0;
    if (kind == 1)
      for (int i = 0; i < 16; i++) if (mask[i]) code = ref_code(i % 4, i / 4);
    if (kind == m_last_kind && code == m_last_code) m_run++;
    else begin
      m_run = 1; m_last_kind = kind; m_last_code = code;
    end
    m_pend = 1'b0;
    if (m_run == DEB) begin
      if (kind == 1) begin
        if (!m_held || code != m_code) begin
          m_code = code; m_pend = 1'b1; m_held = 1'b1; m_err = 1'b0;
        end
      end else if (kind == 0) begin
        m_held = 1'b0; m_err = 1'b0;
      end else begin
        m_held = 1'b0; m_err = 1'b1;
      end
    end
  endtask

  // Runs the first n cycles of a scan; cycle 0 is the first DRIVE cycle of column 0.
  task automatic scan_cycles(input logic [15:0] mask, input int n);
    logic [3:0] exp_col;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        pressed = mask;
        check("key_valid_strobe", 16'(key_valid), 16'(m_pend));
        check("key_code", 16'(key_code), 16'(m_code));
        check("key_held", 16'(key_held), 16'(m_held));
        check("key_err", 16'(key_err), 16'(m_err));
      end else begin
        check("key_valid_quiet", 16'(key_valid), 16'h0);
      end
      exp_col = 4'hF;
      if (i < PERIOD - 1) exp_col[i / COLW] = 1'b0;
      check("col_n", 16'(col_n), 16'(exp_col));
    end
  endtask

  task automatic run_scan(input logic [15:0] mask);
    scan_cycles(mask, PERIOD);
    model_eval(mask);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 16'(dut.state), 16'(IDLE));
    check({tag, "_col_n"}, 16'(col_n), 16'hF);
    check({tag, "_key_code"}, 16'(key_code), 16'h0);
    check({tag, "_key_valid"}, 16'(key_valid), 16'h0);
    check({tag, "_key_held"}, 16'(key_held), 16'h0);
    check({tag, "_key_err"}, 16'(key_err), 16'h0);
  endtask

  localparam logic [15:0] K5 = 16'h0020;  // r1c1
  localparam logic [15:0] K9 = 16'h0400;  // r2c2
  localparam logic [15:0] KA = 16'h1000;  // r0c3
  localparam logic [15:0] KD = 16'h8000;  // r3c3
  localparam logic [15:0] K7 = 16'h0004;  // r2c0

  initial begin
    logic [15:0] mask;
    int kind, reps, b0, b1;

    // Reset with en high and idle rows.
    rst_n = 1'b0; en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_values("reset");
    rst_n = 1'b1;

    // Single key 5 for five scans, then release.
    repeat (5) run_scan(K5);
    repeat (4) run_scan(16'h0);

    // Ghost condition: 5 and 9 together.
    repeat (4) run_scan(K5 | K9);
    repeat (3) run_scan(16'h0);

    // Bouncing A never accepted; steady A, then straight to D.
    for (int s = 0; s < 10; s++) run_scan((s % 2 == 0) ? KA : 16'h0);
    repeat (4) run_scan(KA);
    repeat (4) run_scan(KD);

    // Hold 7, then drop en while column 2 is driven.
    repeat (4) run_scan(K7);
    scan_cycles(K7, 2 * COLW + 2);
    en = 1'b0;
    @(posedge clk); #1;
    model_reset_keep_code();
    check("en_drop_state", 16'(dut.state), 16'(IDLE));
    check("en_drop_col_n", 16'(col_n), 16'hF);
    check("en_drop_key_held", 16'(key_held), 16'(m_held));
    check("en_drop_key_err", 16'(key_err), 16'(m_err));
    check("en_drop_key_code", 16'(key_code), 16'(m_code));
    check("en_drop_key_valid", 16'(key_valid), 16'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_col_n", 16'(col_n), 16'hF);
    end
    en = 1'b1;
    repeat (4) run_scan(K7);

    // Reset pulse in the middle of a scan.
    scan_cycles(K7, COLW + 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_reset_values("mid_reset");
    rst_n = 1'b1;
    pressed = 16'h0;

    // Randomized press patterns held for random scan counts.
    for (int g = 0; g < 14; g++) begin
      kind = $urandom_range(0, 3);
      b0 = $urandom_range(0, 15);
      b1 = (b0 + $urandom_range(1, 15)) % 16;
      mask = 16'h0;
      if (kind == 1 || kind == 2) mask[b0] = 1'b1;
      else if (kind == 3) begin mask[b0] = 1'b1; mask[b1] = 1'b1; end
      reps = $urandom_range(1, 5);
      repeat (reps) run_scan(mask);
    end
    run_scan(16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Disabling the scan clears debounce history and key status but keeps the last code.
  task automatic model_reset_keep_code();
    m_held = 1'b0; m_err = 1'b0; m_pend = 1'b0;
    m_last_kind = 0; m_last_code = 4'h0; m_run = 0;
  endtask

endmodule
